serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one full-subtractor step per clock, LSB first, with the
// borrow carried between bits in a flip-flop and a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; dif/borrow_out hold the last result
// SHIFT | one operand bit processed per edge, WIDTH edges in total
// DONE  | one-cycle result-valid pulse; start here relaunches with no gap
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dif,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, res, res_nxt;
    logic             br, br_nxt, d;
    logic [CW-1:0]    cnt;
    logic             last, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                accept    = start;
                state_nxt = start ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // Full-subtractor cell on the current LSBs; res fills from the MSB down.
    always_comb begin
        d                = sa[0] ^ sb[0] ^ br;
        br_nxt           = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        res_nxt          = res >> 1;
        res_nxt[WIDTH-1] = d;
        last             = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            dif        <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            res <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (state == SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= res_nxt;
            br  <= br_nxt;
            cnt <= cnt + 1'b1;
            // The last bit is folded in here, so take res_nxt rather than res.
            if (last) begin
                dif        <= res_nxt;
                borrow_out <= br_nxt;
            end
        end
    end

endmodule
